// File: rtl/mux2_rr_arbiter.sv
// Two-channel round-robin arbiter feeding a one-entry registered output stage.
// se1 records which channel supplied the beat currently held in out_data.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             se1
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             se1_q, se1_d;
  logic             last_grant_q, last_grant_d;

  logic can_load;
  logic gnt_sel;

  always_comb begin
    can_load = (state_q == EMPTY) | out_ready;

    // Contention favours the channel not granted last; otherwise the lone requester.
    if (in0_valid & in1_valid) begin
      gnt_sel = ~last_grant_q;
    end else begin
      gnt_sel = in1_valid;
    end

    in0_ready = can_load & in0_valid & ~gnt_sel;
    in1_ready = can_load & in1_valid &  gnt_sel;

    state_d      = state_q;
    out_data_d   = out_data_q;
    se1_d        = se1_q;
    last_grant_d = last_grant_q;

    if (in0_ready | in1_ready) begin
      state_d      = FULL;
      out_data_d   = in1_ready ? in1_data : in0_data;
      se1_d        = in1_ready;
      last_grant_d = in1_ready;
    end else if ((state_q == FULL) & out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      se1_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      se1_q        <= se1_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign se1       = se1_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, alternation, backpressure,
// lone requester, drain and mid-operation reset.
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       se1;

  int unsigned n_checks;
  int unsigned n_fails;

  mux2_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .se1       (se1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; registered outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_data [4];
    logic       exp_se1  [4];

    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;

    // 1. Reset then single source
    step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_se1", se1, 0);
    rst_n     = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 8'hA5;
    out_ready = 1'b1;
    #1;
    check_eq("t1_in0_ready", in0_ready, 1);
    check_eq("t1_in1_ready", in1_ready, 0);
    step();
    check_eq("t1_out_valid", out_valid, 1);
    check_eq("t1_out_data", out_data, 8'hA5);
    check_eq("t1_se1", se1, 0);
    in0_valid = 1'b0;

    // 2. Contention alternation, starting from reset so in0 wins first
    pulse_reset();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 8'h11;
    in1_data  = 8'h22;
    out_ready = 1'b1;
    exp_data  = '{8'h11, 8'h22, 8'h11, 8'h22};
    exp_se1   = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("t2_data%0d", i), out_data, exp_data[i]);
      check_eq($sformatf("t2_se1_%0d", i), se1, exp_se1[i]);
    end

    // 3. Backpressure while holding 22
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("t3_in0_ready%0d", i), in0_ready, 0);
      check_eq($sformatf("t3_in1_ready%0d", i), in1_ready, 0);
      step();
      check_eq($sformatf("t3_valid%0d", i), out_valid, 1);
      check_eq($sformatf("t3_data%0d", i), out_data, 8'h22);
      check_eq($sformatf("t3_se1_%0d", i), se1, 1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("t3_rel_in0_ready", in0_ready, 1);
    check_eq("t3_rel_in1_ready", in1_ready, 0);
    step();
    check_eq("t3_rel_data", out_data, 8'h11);
    check_eq("t3_rel_se1", se1, 0);

    // 4. Lone requester on in1
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in1_data = 8'(k);
      #1;
      check_eq($sformatf("t4_in1_ready%0d", k), in1_ready, 1);
      step();
      check_eq($sformatf("t4_data%0d", k), out_data, 32'(k));
      check_eq($sformatf("t4_se1_%0d", k), se1, 1);
    end
    in0_valid = 1'b1;
    in0_data  = 8'h11;
    #1;
    check_eq("t4_both_in0_ready", in0_ready, 1);
    check_eq("t4_both_in1_ready", in1_ready, 0);
    step();
    check_eq("t4_both_data", out_data, 8'h11);
    check_eq("t4_both_se1", se1, 0);

    // 5. Drain to empty after a single in1 beat
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 8'h7E;
    step();
    check_eq("t5_valid", out_valid, 1);
    check_eq("t5_data", out_data, 8'h7E);
    in1_valid = 1'b0;
    step();
    check_eq("t5_drained_valid", out_valid, 0);
    check_eq("t5_drained_data", out_data, 8'h7E);
    check_eq("t5_drained_se1", se1, 1);
    step();
    check_eq("t5_idle_valid", out_valid, 0);

    // 6. Mid-operation reset with output held
    out_ready = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 8'h5A;
    step();
    in1_valid = 1'b0;
    check_eq("t6_loaded_valid", out_valid, 1);
    check_eq("t6_loaded_se1", se1, 1);
    step();
    check_eq("t6_held_data", out_data, 8'h5A);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_se1", se1, 0);
    check_eq("t6_rst_data", out_data, 0);
    #1 rst_n = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 8'h33;
    in1_data  = 8'h44;
    out_ready = 1'b1;
    #1;
    check_eq("t6_in0_ready", in0_ready, 1);
    check_eq("t6_in1_ready", in1_ready, 0);
    step();
    check_eq("t6_data", out_data, 8'h33);
    check_eq("t6_se1", se1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
